// File: rtl/ir_nec_decoder.sv
`timescale 1ns/1ps
// ir_nec_decoder: NEC IR receiver decoder producing {addr, cmd} words with valid/repeat/error strobes.
// Optional feature macro IR_NEC_REPEAT_EN: when defined, NEC repeat codes re-announce the stored word.
module ir_nec_decoder #(
    parameter int CLK_HZ = 50000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ir_rx,
    output logic [15:0] ir_word,
    output logic        ir_valid,
    output logic        ir_repeat,
    output logic        ir_err,
    output logic        busy
);

    localparam int DIV = CLK_HZ / 1000000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [13:0] WIDTH_SAT   = 14'd12000;
    localparam logic [13:0] LEAD_M_MIN  = 14'd8000;
    localparam logic [13:0] LEAD_M_MAX  = 14'd10000;
    localparam logic [13:0] LEAD_S_MIN  = 14'd4000;
    localparam logic [13:0] LEAD_S_MAX  = 14'd5000;
    localparam logic [13:0] REP_S_MIN   = 14'd1800;
    localparam logic [13:0] REP_S_MAX   = 14'd2700;
    localparam logic [13:0] BIT_M_MIN   = 14'd400;
    localparam logic [13:0] BIT_M_MAX   = 14'd750;
    localparam logic [13:0] ZERO_S_MIN  = 14'd400;
    localparam logic [13:0] ZERO_S_MAX  = 14'd750;
    localparam logic [13:0] ONE_S_MIN   = 14'd1400;
    localparam logic [13:0] ONE_S_MAX   = 14'd1950;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_TRAIL_MARK
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_mark;
    logic          r_mark_prev;
    logic [PW-1:0] r_pre;
    logic [13:0]   r_width;
    state_t        r_state;
    logic [31:0]   r_shift;
    logic [4:0]    r_bit;
    logic          r_rep;
    logic [15:0]   r_word;
    logic          r_valid;
    logic          r_err;

    logic          w_rise;
    logic          w_fall;
    logic          w_edge;
    logic          w_tick;
    logic          w_zero_s;
    logic          w_one_s;
    logic          w_unused;

    function automatic logic inWin(input logic [13:0] w, input logic [13:0] lo, input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    // Pin idles high, so the synchronizer resets to 1 and mark (carrier present) starts at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_mark      <= 1'b0;
            r_mark_prev <= 1'b0;
        end else begin
            r_sync1     <= ir_rx;
            r_sync2     <= r_sync1;
            r_mark      <= ~r_sync2;
            r_mark_prev <= r_mark;
        end
    end

    assign w_rise = r_mark & ~r_mark_prev;
    assign w_fall = ~r_mark & r_mark_prev;
    assign w_edge = w_rise | w_fall;
    assign w_tick = (r_pre == PW'(DIV - 1));

    // Every edge restarts both the prescaler phase and the width, keeping width error below 1 us.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_width <= '0;
        end else if (w_edge) begin
            r_pre   <= '0;
            r_width <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            if (r_width < WIDTH_SAT) begin
                r_width <= r_width + 14'd1;
            end
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_zero_s = inWin(r_width, ZERO_S_MIN, ZERO_S_MAX);
    assign w_one_s  = inWin(r_width, ONE_S_MIN, ONE_S_MAX);
    assign w_unused = &{1'b0, r_shift[15:8]};

`ifdef IR_NEC_REPEAT_EN
    logic r_have_word;
    logic r_repeat;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_rep   <= 1'b0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
            r_have_word <= 1'b0;
            r_repeat    <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
`ifdef IR_NEC_REPEAT_EN
            r_repeat <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_state <= S_LEAD_MARK;
                    end
                end
                // A bad leader mark is treated as noise and never reported as an error.
                S_LEAD_MARK: begin
                    if (w_fall) begin
                        r_state <= inWin(r_width, LEAD_M_MIN, LEAD_M_MAX) ? S_LEAD_SPACE : S_IDLE;
                    end else if (r_width > LEAD_M_MAX) begin
                        r_state <= S_IDLE;
                    end
                end
                S_LEAD_SPACE: begin
                    if (w_rise) begin
                        if (inWin(r_width, LEAD_S_MIN, LEAD_S_MAX)) begin
                            r_state <= S_BIT_MARK;
                            r_bit   <= '0;
                            r_shift <= '0;
                            r_rep   <= 1'b0;
                        end else if (inWin(r_width, REP_S_MIN, REP_S_MAX)) begin
`ifdef IR_NEC_REPEAT_EN
                            r_state <= S_TRAIL_MARK;
                            r_rep   <= 1'b1;
`else
                            r_state <= S_IDLE;
`endif
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end else if (r_width > LEAD_S_MAX) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end
                end
                S_BIT_MARK: begin
                    if (w_fall) begin
                        if (inWin(r_width, BIT_M_MIN, BIT_M_MAX)) begin
                            r_state <= S_BIT_SPACE;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end else if (r_width > BIT_M_MAX) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end
                end
                // Bits arrive LSB first, so each new bit enters at the top and shifts down.
                S_BIT_SPACE: begin
                    if (w_rise) begin
                        if (w_zero_s || w_one_s) begin
                            r_shift <= {w_one_s, r_shift[31:1]};
                            r_bit   <= r_bit + 5'd1;
                            r_state <= (r_bit == 5'd31) ? S_TRAIL_MARK : S_BIT_MARK;
                        end else begin
                            r_state <= S_IDLE;
                            r_err   <= 1'b1;
                        end
                    end else if (r_width > ONE_S_MAX) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end
                end
                S_TRAIL_MARK: begin
                    if (w_fall) begin
                        r_state <= S_IDLE;
                        if (!inWin(r_width, BIT_M_MIN, BIT_M_MAX)) begin
                            r_err <= 1'b1;
                        end else if (r_rep) begin
`ifdef IR_NEC_REPEAT_EN
                            if (r_have_word) begin
                                r_valid  <= 1'b1;
                                r_repeat <= 1'b1;
                            end
`endif
                        end else if (r_shift[23:16] == ~r_shift[31:24]) begin
                            r_word  <= {r_shift[7:0], r_shift[23:16]};
                            r_valid <= 1'b1;
`ifdef IR_NEC_REPEAT_EN
                            r_have_word <= 1'b1;
`endif
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (r_width > BIT_M_MAX) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ir_word  = r_word;
    assign ir_valid = r_valid;
    assign ir_err   = r_err;
    assign busy     = (r_state != S_IDLE);
`ifdef IR_NEC_REPEAT_EN
    assign ir_repeat = r_repeat;
`else
    assign ir_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_ir_nec_decoder.sv
`timescale 1ns/1ps
// tb_ir_nec_decoder: drives randomized NEC pulse trains; a frame-level model fills a scoreboard
// queue and a negedge monitor pops and compares every strobe the decoder emits.
module tb_ir_nec_decoder;

    localparam int CLK_HZ = 2000000;
    localparam int DIV    = CLK_HZ / 1000000;

    logic        clock = 1'b0;
    logic        reset;
    logic        ir_rx;
    logic [15:0] ir_word;
    logic        ir_valid;
    logic        ir_repeat;
    logic        ir_err;
    logic        busy;

    typedef enum logic [1:0] {EV_WORD, EV_REPEAT, EV_ERR, EV_BAD} evKind_t;
    typedef struct packed {
        evKind_t     kind;
        logic [15:0] word;
    } event_t;

    event_t      sbQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    logic [15:0] modelWord = 16'h0000;
    logic        modelHave = 1'b0;

    always #5 clock = ~clock;

    ir_nec_decoder #(.CLK_HZ(CLK_HZ)) dut (
        .clock     (clock),
        .reset     (reset),
        .ir_rx     (ir_rx),
        .ir_word   (ir_word),
        .ir_valid  (ir_valid),
        .ir_repeat (ir_repeat),
        .ir_err    (ir_err),
        .busy      (busy)
    );

    // Monitor: every strobe cycle must match the oldest expected event, word included.
    always @(negedge clock) begin
        event_t  expEv;
        evKind_t actKind;
        if (!reset && (ir_valid || ir_err || ir_repeat)) begin
            if (ir_err && !ir_valid && !ir_repeat)       actKind = EV_ERR;
            else if (ir_valid && ir_repeat && !ir_err)   actKind = EV_REPEAT;
            else if (ir_valid && !ir_repeat && !ir_err)  actKind = EV_WORD;
            else                                         actKind = EV_BAD;
            nChecks++;
            if (sbQ.size() == 0) begin
                nFails++;
                $display("[TB] FAIL unexpected_pulse: got kind=%0d word=%h, required no pulse", actKind, ir_word);
            end else begin
                expEv = sbQ.pop_front();
                if (actKind != expEv.kind || ir_word != expEv.word) begin
                    nFails++;
                    $display("[TB] FAIL strobe: got kind=%0d word=%h, required kind=%0d word=%h",
                             actKind, ir_word, expEv.kind, expEv.word);
                end
            end
        end
    end

    function automatic int pick(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic void expectFrame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] cInv);
        if (c == ~cInv) begin
            modelWord = {a, c};
            modelHave = 1'b1;
            sbQ.push_back('{kind: EV_WORD, word: modelWord});
        end else begin
            sbQ.push_back('{kind: EV_ERR, word: modelWord});
        end
    endfunction

    function automatic void expectRepeat();
`ifdef IR_NEC_REPEAT_EN
        if (modelHave) sbQ.push_back('{kind: EV_REPEAT, word: modelWord});
`endif
    endfunction

    task automatic applyStimulus(input logic lvl, input int us);
        ir_rx = lvl;
        repeat (us * DIV) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sbQ.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain: %0d events still pending, required 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic sendLeader();
        applyStimulus(1'b0, pick(8100, 8500));
        applyStimulus(1'b1, pick(4100, 4400));
    endtask

    task automatic sendBits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, pick(420, 520));
            applyStimulus(1'b1, data[i] ? pick(1420, 1520) : pick(420, 520));
        end
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] c,
                             input logic [7:0] aInv, input logic [7:0] cInv);
        expectFrame(a, c, cInv);
        sendLeader();
        sendBits({cInv, c, aInv, a}, 32);
        applyStimulus(1'b0, pick(420, 520));
        applyStimulus(1'b1, 100);
        waitDrain(200);
        checkOutput("busy_after_frame", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rc;
        logic [7:0] rcInv;

        reset = 1'b1;
        ir_rx = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checkOutput("reset_word",   ir_word, 16'h0000);
        checkOutput("reset_valid",  {15'd0, ir_valid}, 16'd0);
        checkOutput("reset_repeat", {15'd0, ir_repeat}, 16'd0);
        checkOutput("reset_err",    {15'd0, ir_err}, 16'd0);
        checkOutput("reset_busy",   {15'd0, busy}, 16'd0);
        reset = 1'b0;
        applyStimulus(1'b1, 50);

        // Noise leader mark: silently ignored, then a normal frame.
        applyStimulus(1'b0, 7000);
        applyStimulus(1'b1, 300);
        waitDrain(10);
        checkOutput("busy_after_noise", {15'd0, busy}, 16'd0);
        sendFrame(8'h04, 8'h2C, 8'hFB, 8'hD3);
        checkOutput("word_042C", ir_word, 16'h042C);

        // Bad checksum keeps the previous word.
        sendFrame(8'h04, 8'h2C, 8'hFB, 8'hD2);
        checkOutput("word_after_badsum", ir_word, 16'h042C);

        // Repeat code.
        expectRepeat();
        applyStimulus(1'b0, pick(8100, 8500));
        applyStimulus(1'b1, pick(2000, 2500));
        applyStimulus(1'b0, pick(420, 520));
        applyStimulus(1'b1, 100);
        waitDrain(200);
        checkOutput("word_after_repeat", ir_word, 16'h042C);

        // Stall inside bit 10's mark: the error must arrive before the mark ends.
        sbQ.push_back('{kind: EV_ERR, word: modelWord});
        sendLeader();
        sendBits($urandom(), 10);
        applyStimulus(1'b0, 1000);
        waitDrain(0);
        applyStimulus(1'b1, 100);
        checkOutput("busy_after_stall", {15'd0, busy}, 16'd0);

        for (int k = 0; k < 2; k++) begin
            ra    = 8'($urandom());
            rc    = 8'($urandom());
            rcInv = ($urandom_range(1) == 0) ? ~rc : (~rc ^ (8'h01 << $urandom_range(7)));
            sendFrame(ra, rc, 8'($urandom()), rcInv);
            checkOutput("word_random", ir_word, modelWord);
        end

        // Reset during bit 20: everything clears, no strobes.
        sendLeader();
        sendBits($urandom(), 20);
        ir_rx = 1'b0;
        repeat (200) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_word",  ir_word, 16'h0000);
        checkOutput("midreset_valid", {15'd0, ir_valid}, 16'd0);
        checkOutput("midreset_err",   {15'd0, ir_err}, 16'd0);
        checkOutput("midreset_busy",  {15'd0, busy}, 16'd0);
        modelWord = 16'h0000;
        modelHave = 1'b0;
        ir_rx = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1'b1, 100);

        // Repeat with nothing stored since reset stays silent.
        expectRepeat();
        applyStimulus(1'b0, pick(8100, 8500));
        applyStimulus(1'b1, pick(2000, 2500));
        applyStimulus(1'b0, pick(420, 520));
        applyStimulus(1'b1, 100);
        waitDrain(200);
        checkOutput("word_after_orphan_repeat", ir_word, 16'h0000);

        sendFrame(8'h12, 8'h34, 8'hED, 8'hCB);
        checkOutput("word_1234", ir_word, 16'h1234);

        waitDrain(50);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ir_nec_decoder.md
# ir_nec_decoder

Decodes the demodulated output of an IR receiver module, using the NEC protocol, into a 16-bit {address, command} word. A 1-cycle strobe marks each new word. One instance sits per player, between the IR receiver input pin and the 16-bit `ir_in_p1`/`ir_in_p2` reading consumed by the graphics/VGA path. It is the receiving end of the player wands' NEC transmitters.

## Interface
- `CLK_HZ`, default 50000000: clock frequency. `CLK_HZ/1000000` must be an integer ≥ 2.
- `clock`  in  1: system clock (CLOCK_50 domain).
- `reset`  in  1: asynchronous, active-high reset.
- `ir_rx`  in  1: raw receiver output, asynchronous. Idle high; mark (carrier present) = low.
- `ir_word`  out  16: last valid frame as {addr[7:0], cmd[7:0]}. Held between frames.
- `ir_valid`  out  1: 1-cycle pulse when `ir_word` is updated, or when a repeat is accepted.
- `ir_repeat`  out  1: 1-cycle pulse, coincident with `ir_valid`, for a repeat code.
- `ir_err`  out  1: 1-cycle pulse when a frame aborts after an accepted leader.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- **Input path:** `ir_rx` passes through a 2-FF synchronizer, then is inverted to `mark` (1 = carrier). Edges are detected on the synchronized `mark`.
- **Timebase:** a prescaler counts `CLK_HZ/1e6` cycles and emits a 1 µs tick. A 14-bit `width_us` counter restarts at 0 on every `mark` edge and increments per tick. It saturates at 12000.
- **Classification windows** (µs, inclusive):
  - LEAD_M: 8000–10000
  - LEAD_S: 4000–5000
  - REP_S: 1800–2700
  - BIT_M: 400–750
  - ZERO_S: 400–750
  - ONE_S: 1400–1950
- **FSM states:** IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, TRAIL_MARK.
  - **IDLE:** a `mark` rising edge goes to LEAD_MARK.
  - **LEAD_MARK:** on the `mark` falling edge, go to LEAD_SPACE if width is in LEAD_M; otherwise go to IDLE with no error. This is treated as noise.
  - **LEAD_SPACE:** on the rising edge:
    - width in LEAD_S → BIT_MARK, bit index 0, shift register cleared.
    - width in REP_S → TRAIL_MARK with the repeat flag set.
    - otherwise → IDLE and pulse `ir_err`.
  - **BIT_MARK:** on the falling edge, go to BIT_SPACE if width is in BIT_M; otherwise abort.
  - **BIT_SPACE:** on the rising edge, a ZERO_S width shifts in 0 and an ONE_S width shifts in 1.
    - Bits arrive LSB first into a 32-bit register holding {~cmd, cmd, ~addr, addr}.
    - After bit 31 → TRAIL_MARK; otherwise → BIT_MARK.
    - Any other width aborts.
  - **TRAIL_MARK:** on the falling edge, if width is in BIT_M:
    - Frame case: if cmd == ~cmd_inv, load `ir_word` = {addr, cmd} and pulse `ir_valid`; otherwise pulse `ir_err` and leave `ir_word` unchanged. The ~addr byte is not checked, so extended NEC is accepted.
    - Repeat case: see Configuration.
    - A width outside BIT_M aborts.
  - In every state, go to IDLE.
- **Abort:** enter IDLE and pulse `ir_err`. This applies after leader acceptance only.
- **Timeout:** in any non-IDLE state, if `width_us` exceeds the maximum of the current window (mark or space), abort immediately without waiting for an edge.
- **No-edge rule:** no edge occurring in the same cycle as a state entry is missed. The edge that causes a transition also starts the next measurement at 0.
- **Outputs at reset:** `ir_word`=0, `ir_valid`=0, `ir_repeat`=0, `ir_err`=0, `busy`=0. FSM goes to IDLE, counters to 0, the synchronizer to idle (`mark`=0), and the "last word valid" flag to 0.
- **Reset mid-frame:** the frame is discarded and no pulse is produced. The first complete frame after reset decodes normally.

## Timing
- A `mark` edge is seen 3 clocks after the pin edge: 2 synchronizer stages plus 1 edge register.
- `ir_valid`, `ir_repeat` and `ir_err` are registered and assert 1 clock after the deciding edge or timeout detection. Each is high for exactly 1 cycle.
- Frame latency is about 67.5 ms from leader start. Repeat latency is about 11.8 ms.
- Width resolution is 1 µs. With the prescaler phase restarting at each edge, the error is < 1 µs.
- `busy` rises 1 clock after the leader edge is detected and falls in the same cycle the FSM re-enters IDLE.

## Configuration
- `IR_NEC_REPEAT_EN` defined:
  - An accepted repeat code with a stored word pulses `ir_valid` and `ir_repeat` together; `ir_word` is unchanged.
  - A repeat with no stored word since reset returns to IDLE silently.
- Not defined:
  - A REP_S space is handled as an invalid LEAD_SPACE, so the FSM goes to IDLE with no `ir_err`.
  - `ir_repeat` is tied to 0.

## Test plan
- **Valid frame:** addr 0x04, cmd 0x2C at `CLK_HZ`=50 MHz → exactly one `ir_valid`, `ir_word`=0x042C, `ir_err`=0, `busy` low after the trailing mark.
- **Bad checksum:** send a frame with byte3 = 0xD2 instead of 0xD3 → one `ir_err`, no `ir_valid`, `ir_word` keeps its prior value.
- **Repeat code:** send a frame followed by 9000/2250/560 µs.
  - With `IR_NEC_REPEAT_EN`: `ir_valid`=`ir_repeat`=1 for one cycle, `ir_word` unchanged.
  - Without it: no pulses at all.
- **Noise leader:** a 7000 µs mark → back to IDLE, no `ir_err`. A valid frame right after still decodes.
- **Stall:** ir_rx is held low (mark) for 1000 µs during bit 10 → `ir_err` pulses once the width passes 750 µs, well before the edge. FSM returns to IDLE.
- **Reset mid-frame:** assert `reset` during bit 20 → all outputs 0 immediately, no pulses. The next full frame (0x1234... checksum-valid) decodes correctly.
